// File: rtl/imem_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words,
// writes them to consecutive instruction-memory words, then releases the core.
module imem_loader #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32,
  parameter int MAX_WORDS     = 256
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     start,
  input  logic [15:0]              word_count,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     imem_we,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  output logic [INSTR_WIDTH-1:0]   imem_wdata,
  output logic                     cpu_rst,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [15:0]            count_q, count_d;
  logic [15:0]            word_idx_q, word_idx_d;
  logic [1:0]             byte_idx_q, byte_idx_d;
  logic [INSTR_WIDTH-1:0] wbuf_q, wbuf_d;
  logic [17:0]            addr_s;

  function automatic logic len_ok(input logic [15:0] wc);
    return (wc != 16'd0) && (wc <= 16'(MAX_WORDS));
  endfunction

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    wbuf_d     = wbuf_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          if (len_ok(word_count)) begin
            count_d    = word_count;
            word_idx_d = 16'd0;
            byte_idx_d = 2'd0;
            state_d    = S_COLLECT;
          end else begin
            state_d = S_ERROR;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_COLLECT: begin
        if (byte_valid) begin
          case (byte_idx_q)
            2'd0:    wbuf_d[7:0]   = byte_in;
            2'd1:    wbuf_d[15:8]  = byte_in;
            2'd2:    wbuf_d[23:16] = byte_in;
            2'd3:    wbuf_d[31:24] = byte_in;
            default: wbuf_d        = wbuf_q;
          endcase
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_WRITE: begin
        // Write happens this cycle; the index advances on the closing edge.
        word_idx_d = word_idx_q + 16'd1;
        byte_idx_d = 2'd0;
        if (word_idx_d == count_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= 16'd0;
      word_idx_q <= 16'd0;
      byte_idx_q <= 2'd0;
      wbuf_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      wbuf_q     <= wbuf_d;
    end
  end

  // Outputs decode only registered state, so an async reset drops imem_we at once.
  assign addr_s     = {word_idx_q, 2'b00};
  assign imem_addr  = ADDRESS_WIDTH'(addr_s);
  assign imem_wdata = wbuf_q;
  assign byte_ready = (state_q == S_COLLECT);
  assign imem_we    = (state_q == S_WRITE);
  assign busy       = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERROR);
  assign cpu_rst    = (state_q != S_DONE);

endmodule
